// File: rtl/bcd_timer_nd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_nd_pkg
// Description : Shared BCD constants, state encodings and the per-digit limit
//               helper for the N-digit BCD timer.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_timer_nd_pkg;

    localparam int         BCD_BIT_WIDTH = 4;
    localparam logic [3:0] BCD_ZERO      = 4'd0;
    localparam logic [3:0] BCD_FIVE      = 4'd5;
    localparam logic [3:0] BCD_NINE      = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Wrap limit of digit idx: odd digits are tens-of-seconds/minutes in time mode.
    function automatic logic [3:0] digit_limit(input logic time_mode, input int idx);
        return (time_mode && ((idx % 2) == 1)) ? BCD_FIVE : BCD_NINE;
    endfunction

endpackage : bcd_timer_nd_pkg
`default_nettype wire

// File: rtl/bcd_digit_updown.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_updown
// Description : One BCD digit with decrement/increment, programmable wrap
//               limit, synchronous load, and borrow/carry to the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_updown
    import bcd_timer_nd_pkg::*;
#(
    parameter logic [BCD_BIT_WIDTH-1:0] INIT_DIGIT = BCD_ZERO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec,
    input  logic                     inc,
    input  logic [BCD_BIT_WIDTH-1:0] limit,
    input  logic                     load,
    input  logic [BCD_BIT_WIDTH-1:0] load_value,
    output logic [BCD_BIT_WIDTH-1:0] value,
    output logic [BCD_BIT_WIDTH-1:0] next_value,
    output logic                     borrow,
    output logic                     carry
);

    logic [BCD_BIT_WIDTH-1:0] r_value;
    logic [BCD_BIT_WIDTH-1:0] w_next;
    logic                     w_borrow;
    logic                     w_carry;

    // Next digit value for this cycle's step; an unclamped digit above the
    // limit counts down normally and wraps to zero on the way up.
    always_comb begin
        w_next   = r_value;
        w_borrow = 1'b0;
        w_carry  = 1'b0;
        if (dec) begin
            if (r_value == BCD_ZERO) begin
                w_next   = limit;
                w_borrow = 1'b1;
            end else begin
                w_next = r_value - 4'd1;
            end
        end else if (inc) begin
            if (r_value >= limit) begin
                w_next  = BCD_ZERO;
                w_carry = 1'b1;
            end else begin
                w_next = r_value + 4'd1;
            end
        end
    end

    // Digit register: reset, then load, then step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= INIT_DIGIT;
        end else if (load) begin
            r_value <= load_value;
        end else begin
            r_value <= w_next;
        end
    end

    assign value      = r_value;
    assign next_value = w_next;
    assign borrow     = w_borrow;
    assign carry      = w_carry;

endmodule : bcd_digit_updown
`default_nettype wire

// File: rtl/bcd_timer_nd.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_nd
// Description : N-digit BCD up/down timer with decimal or MM:SS wrap limits,
//               load clamping and an IDLE/RUN/PAUSE/DONE control machine.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer_nd
    import bcd_timer_nd_pkg::*;
#(
    parameter int                          NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]     INIT_VALUE = 'h1125
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    dir,
    input  logic                    time_mode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [1:0]              state,
    output logic                    running,
    output logic                    done
);

    logic [1:0]              r_state;
    logic                    r_done;
    logic                    r_running;
    logic [1:0]              w_state_nxt;
    logic                    w_done_nxt;

    logic [4*NUM_DIGITS-1:0] w_digits;
    logic [4*NUM_DIGITS-1:0] w_next_digits;
    logic [4*NUM_DIGITS-1:0] w_limits;
    logic [4*NUM_DIGITS-1:0] w_load_clamped;
    logic [NUM_DIGITS-1:0]   w_dec;
    logic [NUM_DIGITS-1:0]   w_inc;
    logic [NUM_DIGITS-1:0]   w_borrow;
    logic [NUM_DIGITS-1:0]   w_carry;

    logic w_start_req;
    logic w_pause_req;
    logic w_step;
    logic w_all_zero;
    logic w_all_lim;
    logic w_all_ge;
    logic w_nxt_zero;
    logic w_nxt_lim;
    logic w_cur_term;
    logic w_at_end;
    logic w_next_term;
    logic w_unused_msd;

    // start and pause together cancel each other.
    assign w_start_req = start & ~pause;
    assign w_pause_req = pause & ~start;

    // At the end of travel (terminal, or every digit at/above its limit going
    // up) a step would wrap the whole counter, so it is suppressed.
    assign w_step = (r_state == ST_RUN) & tick & ~w_pause_req & ~load & ~w_at_end;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_limits[4*i +: 4]       = digit_limit(time_mode, i);
            assign w_load_clamped[4*i +: 4] = (load_value[4*i +: 4] > w_limits[4*i +: 4])
                                            ? w_limits[4*i +: 4] : load_value[4*i +: 4];
            if (i == 0) begin : g_lsb
                assign w_dec[i] = w_step & ~dir;
                assign w_inc[i] = w_step &  dir;
            end else begin : g_chain
                assign w_dec[i] = w_borrow[i-1];
                assign w_inc[i] = w_carry[i-1];
            end

            bcd_digit_updown #(
                .INIT_DIGIT (INIT_VALUE[4*i +: 4])
            ) u_digit (
                .clk        (clk),
                .rst        (rst),
                .dec        (w_dec[i]),
                .inc        (w_inc[i]),
                .limit      (w_limits[4*i +: 4]),
                .load       (load),
                .load_value (w_load_clamped[4*i +: 4]),
                .value      (w_digits[4*i +: 4]),
                .next_value (w_next_digits[4*i +: 4]),
                .borrow     (w_borrow[i]),
                .carry      (w_carry[i])
            );
        end
    endgenerate

    // Borrow/carry out of the top digit cannot occur because end-of-travel
    // blocks the step that would produce it.
    assign w_unused_msd = w_borrow[NUM_DIGITS-1] | w_carry[NUM_DIGITS-1];

    // Terminal / end-of-travel detection on the current and next digit values.
    always_comb begin
        w_all_zero = 1'b1;
        w_all_lim  = 1'b1;
        w_all_ge   = 1'b1;
        w_nxt_zero = 1'b1;
        w_nxt_lim  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_digits[4*d +: 4] != BCD_ZERO)                 w_all_zero = 1'b0;
            if (w_digits[4*d +: 4] != w_limits[4*d +: 4])       w_all_lim  = 1'b0;
            if (w_digits[4*d +: 4] <  w_limits[4*d +: 4])       w_all_ge   = 1'b0;
            if (w_next_digits[4*d +: 4] != BCD_ZERO)            w_nxt_zero = 1'b0;
            if (w_next_digits[4*d +: 4] != w_limits[4*d +: 4])  w_nxt_lim  = 1'b0;
        end
    end

    assign w_cur_term  = dir ? w_all_lim : w_all_zero;
    assign w_at_end    = dir ? w_all_ge  : w_all_zero;
    assign w_next_term = dir ? w_nxt_lim : w_nxt_zero;

    // Next-state and done-pulse decision; load overrides all control requests.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (w_start_req) begin
                        if (w_cur_term) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_pause_req) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick && (w_at_end || w_next_term)) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Registered state, done pulse and running flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign digits  = w_digits;
    assign state   = r_state;
    assign running = r_running;
    assign done    = r_done;

endmodule : bcd_timer_nd
`default_nettype wire

// File: tb/tb_bcd_timer_nd.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_timer_nd
// Description : Self-checking bench for bcd_timer_nd (4-digit and 6-digit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_timer_nd;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic [23:0] load_value6 = 24'h0;
    logic        dir = 1'b0;
    logic        time_mode = 1'b0;

    logic [15:0] digits4;
    logic [1:0]  state4;
    logic        running4;
    logic        done4;
    logic [23:0] digits6;
    logic [1:0]  state6;
    logic        running6;
    logic        done6;

    int checks = 0;
    int errors = 0;
    int dcnt4  = 0;
    int dcnt6  = 0;

    bcd_timer_nd dut4 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .load(load), .load_value(load_value), .dir(dir), .time_mode(time_mode),
        .digits(digits4), .state(state4), .running(running4), .done(done4)
    );

    bcd_timer_nd #(.NUM_DIGITS(6), .INIT_VALUE(24'h001125)) dut6 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .load(load), .load_value(load_value6), .dir(dir), .time_mode(time_mode),
        .digits(digits6), .state(state6), .running(running6), .done(done6)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done4 === 1'b1) dcnt4 = dcnt4 + 1;
        if (done6 === 1'b1) dcnt6 = dcnt6 + 1;
    end

    typedef struct {
        logic [15:0] lv;
        logic        tm;
        logic        dir;
        logic        do_start;
        int          nt;
        logic [15:0] exp_d;
        logic [1:0]  exp_st;
        int          exp_done;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        int base;
        dir        = vecs[idx].dir;
        time_mode  = vecs[idx].tm;
        load_value = vecs[idx].lv;
        load = 1'b1; step(); load = 1'b0;
        base = dcnt4;
        if (vecs[idx].do_start) begin
            start = 1'b1; step(); start = 1'b0;
        end
        for (int t = 0; t < vecs[idx].nt; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        @(negedge clk); #1;
        chk($sformatf("vec%0d digits", idx), {16'h0, digits4}, {16'h0, vecs[idx].exp_d});
        chk($sformatf("vec%0d state", idx), {30'h0, state4}, {30'h0, vecs[idx].exp_st});
        chk($sformatf("vec%0d running", idx), {31'h0, running4},
            {31'h0, (vecs[idx].exp_st == S_RUN)});
        chk($sformatf("vec%0d done_count", idx), dcnt4 - base, vecs[idx].exp_done);
    endtask

    initial begin
        int base;
        //           lv        tm    dir   start nt  exp_d     exp_st   done
        vecs[0]  = '{16'h0100, 1'b1, 1'b0, 1'b1, 1, 16'h0059, S_RUN,  0};
        vecs[1]  = '{16'h0100, 1'b0, 1'b0, 1'b1, 1, 16'h0099, S_RUN,  0};
        vecs[2]  = '{16'h5958, 1'b1, 1'b1, 1'b1, 1, 16'h5959, S_DONE, 1};
        vecs[3]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 0, 16'h0000, S_DONE, 1};
        vecs[4]  = '{16'h9A7F, 1'b1, 1'b0, 1'b0, 0, 16'h5959, S_IDLE, 0};
        vecs[5]  = '{16'h0009, 1'b0, 1'b1, 1'b1, 1, 16'h0010, S_RUN,  0};
        vecs[6]  = '{16'h0959, 1'b1, 1'b1, 1'b1, 1, 16'h1000, S_RUN,  0};
        vecs[7]  = '{16'h1000, 1'b1, 1'b0, 1'b1, 1, 16'h0959, S_RUN,  0};
        vecs[8]  = '{16'h9998, 1'b0, 1'b1, 1'b1, 1, 16'h9999, S_DONE, 1};
        vecs[9]  = '{16'h0001, 1'b0, 1'b0, 1'b1, 3, 16'h0000, S_DONE, 1};
        vecs[10] = '{16'h5959, 1'b1, 1'b1, 1'b1, 0, 16'h5959, S_DONE, 1};
        vecs[11] = '{16'h9999, 1'b1, 1'b0, 1'b1, 2, 16'h5957, S_RUN,  0};

        // Reset state
        step();
        chk("reset digits", {16'h0, digits4}, 32'h1125);
        chk("reset state", {30'h0, state4}, {30'h0, S_IDLE});
        chk("reset running", {31'h0, running4}, 32'h0);
        chk("reset done", {31'h0, done4}, 32'h0);
        rst = 1'b0;

        // Full countdown from the reset value, then ticks held in DONE
        base = dcnt4;
        start = 1'b1; step(); start = 1'b0;
        for (int t = 0; t < 1125; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        @(negedge clk); #1;
        chk("countdown digits", {16'h0, digits4}, 32'h0000);
        chk("countdown state", {30'h0, state4}, {30'h0, S_DONE});
        chk("countdown done_count", dcnt4 - base, 1);
        for (int t = 0; t < 5; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        @(negedge clk); #1;
        chk("done hold digits", {16'h0, digits4}, 32'h0000);
        chk("done hold state", {30'h0, state4}, {30'h0, S_DONE});
        chk("done hold done_count", dcnt4 - base, 1);

        // Table of load/start/tick vectors
        for (int v = 0; v < 12; v++) run_vec(v);

        // Pause with tick, ticks in PAUSE, resume
        dir = 1'b0; time_mode = 1'b0; load_value = 16'h0042;
        load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
        chk("pause+tick digits", {16'h0, digits4}, 32'h0042);
        chk("pause+tick state", {30'h0, state4}, {30'h0, S_PAUSE});
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        chk("paused ticks digits", {16'h0, digits4}, 32'h0042);
        chk("paused ticks state", {30'h0, state4}, {30'h0, S_PAUSE});
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        chk("resume digits", {16'h0, digits4}, 32'h0041);
        chk("resume state", {30'h0, state4}, {30'h0, S_RUN});

        // Tick in the start cycle is not counted; start+pause keeps RUN and ticks
        load_value = 16'h0042;
        load = 1'b1; step(); load = 1'b0;
        start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
        chk("start+tick digits", {16'h0, digits4}, 32'h0042);
        chk("start+tick state", {30'h0, state4}, {30'h0, S_RUN});
        start = 1'b1; pause = 1'b1; tick = 1'b1; step();
        start = 1'b0; pause = 1'b0; tick = 1'b0;
        chk("start+pause+tick digits", {16'h0, digits4}, 32'h0041);
        chk("start+pause+tick state", {30'h0, state4}, {30'h0, S_RUN});

        // start and pause ignored in DONE
        dir = 1'b1; time_mode = 1'b1; load_value = 16'h5958;
        load = 1'b1; step(); load = 1'b0;
        base = dcnt4;
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        pause = 1'b1; step(); pause = 1'b0;
        @(negedge clk); #1;
        chk("done start digits", {16'h0, digits4}, 32'h5959);
        chk("done start state", {30'h0, state4}, {30'h0, S_DONE});
        chk("done start done_count", dcnt4 - base, 1);

        // Six-digit instance: count to zero, then reset mid-RUN
        dir = 1'b0; time_mode = 1'b0; load_value6 = 24'h000001;
        load = 1'b1; step(); load = 1'b0;
        base = dcnt6;
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        @(negedge clk); #1;
        chk("n6 digits", {8'h0, digits6}, 32'h000000);
        chk("n6 state", {30'h0, state6}, {30'h0, S_DONE});
        chk("n6 done_count", dcnt6 - base, 1);
        load_value6 = 24'h000500;
        load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        chk("n6 borrow digits", {8'h0, digits6}, 32'h000499);
        rst = 1'b1; tick = 1'b1; step(); rst = 1'b0; tick = 1'b0;
        chk("n6 rst digits", {8'h0, digits6}, 32'h001125);
        chk("n6 rst state", {30'h0, state6}, {30'h0, S_IDLE});
        chk("n6 rst running", {31'h0, running6}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bcd_timer_nd
`default_nettype wire

// File: doc/bcd_timer_nd.md
# bcd_timer_nd

Parametrised N-digit BCD timer, the next generation of the fixed 4-digit down counter. It counts a loadable BCD preset down or up on an external tick, in decimal or MM:SS-style time mode, under a start/pause/done state machine. It sits between the 1 Hz tick divider and the 7-segment scan/display logic. Stopwatch and countdown displays instantiate it with `NUM_DIGITS` = 2..8.

## Interface
- `NUM_DIGITS`, 4: number of BCD digits, range 2..8; digit 0 is least significant.
- `INIT_VALUE`, 'h1125: reset value of `digits`, 4*`NUM_DIGITS` bits.
- `clk` input 1: global clock; all state updates on its rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `tick` input 1: count-enable pulse, one `clk` cycle wide, from the divider.
- `start` input 1: level-sampled request to enter RUN.
- `pause` input 1: level-sampled request to leave RUN.
- `load` input 1: load `load_value` and return to IDLE.
- `load_value` input 4*`NUM_DIGITS`: BCD preset.
- `dir` input 1: 0 = count down, 1 = count up.
- `time_mode` input 1: 1 = odd-indexed digits wrap at 5, even-indexed digits at 9; 0 = all digits wrap at 9.
- `digits` output 4*`NUM_DIGITS`: current BCD value.
- `state` output 2: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- `running` output 1: high iff `state` == RUN.
- `done` output 1: one-cycle pulse on reaching terminal value.

## Operation
- Digit limit: digit i has limit L(i) = 5 if `time_mode` and i is odd, else 9.
- Terminal value:
  - Down: all digits 0.
  - Up: every digit i at L(i), e.g. 9999 decimal or 5959 time mode for N=4.
- Down step: digit 0 decrements. A digit at 0 wraps to L(i) and borrows into digit i+1. Borrow ripples combinationally within one cycle.
- Up step: digit 0 increments. A digit at L(i) wraps to 0 and carries into digit i+1.
- Priority per cycle: `rst` > `load` > `start`/`pause` > `tick`.
- Load:
  - Allowed in any state; `state` becomes IDLE and `done` is not asserted.
  - Any load digit greater than its L(i) under the current `time_mode` is clamped to L(i).
- State transitions:
  - IDLE: `start` -> RUN; if `digits` already equal the terminal value for `dir`, go to DONE instead and pulse `done`.
  - RUN: `pause` -> PAUSE. Otherwise `tick` steps the value. If the step lands on the terminal value, go to DONE and pulse `done` on that same edge.
  - PAUSE: `start` -> RUN (same terminal check as IDLE). `tick` is ignored.
  - DONE: hold `digits`. Only `load` or `rst` leave this state; `start` and `pause` are ignored.
- Simultaneous events:
  - `start` and `pause` asserted together: no state change. A `tick` in that cycle is still applied if the state is RUN.
  - `pause` and `tick` together in RUN: pause wins; no step.
- Changing `dir` or `time_mode` mid-RUN takes effect on the next tick. Existing digits are not re-clamped.
- No wrap past the terminal value in either direction; the counter stops in DONE.

## Timing
- Reset values: `digits` = `INIT_VALUE`, `state` = IDLE, `running` = 0, `done` = 0.
- `rst` mid-RUN overrides everything on that edge.
- `tick` sampled at edge k in RUN: the new `digits` are visible after edge k (latency 1).
- `done` is registered: high for exactly the cycle following the edge that entered DONE.
- `start` or `load` -> `state` updates after 1 edge.
- The first `tick` counts only if it arrives in a cycle where `state` already reads RUN.
- Outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared global definitions hold `BCD_BIT_WIDTH`, `BCD_ZERO`, `BCD_FIVE`, `BCD_NINE`, and the four state encodings.
- Sub-module `bcd_digit_updown`: one digit with `dec`/`inc`, `limit`, `load`, and `load_value` inputs, and `value` and `borrow`/`carry` outputs.
  - Instantiated `NUM_DIGITS` times via generate, with the enable chained.
- The state machine, terminal detect, and clamp logic live in the top level.

## Test plan
- Reset with default parameters -> `digits` = 1125, IDLE, `done` = 0. Then `start` plus 1125 ticks, down, decimal mode -> value hits 0000, `done` pulses once, DONE held through 5 extra ticks.
- Load 0100, `time_mode` = 1, down, `start`, 1 tick -> 0059. Repeat with `time_mode` = 0 -> 0099.
- Load 5958, time mode, up, `start`, 1 tick -> 5959, `done` pulses, state DONE. Another `start` in DONE -> no change.
- RUN at 0042: `pause` together with `tick` -> stays 0042, PAUSE. 3 ticks in PAUSE -> 0042. `start`, 1 tick -> 0041.
- Load 0000, down, `start` -> DONE with `done` pulse and no tick needed. Load 9A7F in time mode -> clamped to 5959.
- `NUM_DIGITS` = 6, load 000001, 1 tick -> 000000 and `done`. `rst` mid-RUN -> `INIT_VALUE` and IDLE on the next edge.
